// File: rtl/behav_seq_pkg.sv
// Shared types for the behav_seq_ctrl vector sequencer: FSM states and the
// packed table entry layout {a, b, c, exp_y}.
package behav_seq_pkg;

  localparam int VEC_W = 4;
  localparam int CNT_W = 4;  // wide enough for SETTLE_CYC up to 15

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic exp_y;
  } vec_t;

endpackage

// File: rtl/behav_vec_ram.sv
// DEPTH x 4 vector table: one synchronous write port, one combinational read port.
module behav_vec_ram
  import behav_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  vec_t             wdata,
  input  logic [IDX_W-1:0] raddr,
  output vec_t             rdata
);

  vec_t mem [DEPTH];

  // NOTE: storage is deliberately not reset; entries are undefined until
  // written, and leaving reset off keeps this a plain register file.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/behav_seq_ctrl.sv
// Vector sequencer: applies table entries to a/b/c, waits SETTLE_CYC cycles,
// samples y against the expected bit and reports pass/err_cnt/first_fail.
module behav_seq_ctrl
  import behav_seq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [VEC_W-1:0] wr_vec,
  input  logic [IDX_W:0]   num_vecs,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   err_cnt,
  output logic [IDX_W-1:0] first_fail
);

  localparam logic [IDX_W:0]   DEPTH_V  = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC - 1);

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [IDX_W:0]   nv_q, nv_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             a_q, a_n, b_q, b_n, c_q, c_n;
  logic             busy_q, busy_n, done_q, done_n, pass_q, pass_n;
  logic [IDX_W:0]   err_q, err_n;
  logic [IDX_W-1:0] ff_q, ff_n;

  vec_t             rd_vec;
  logic             idle_like;
  logic             mismatch;
  logic             last_vec;
  logic [IDX_W:0]   nv_clamp;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);

  behav_vec_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en && idle_like),
    .waddr (wr_addr),
    .wdata (vec_t'(wr_vec)),
    .raddr (idx_q),
    .rdata (rd_vec)
  );

  assign nv_clamp = (num_vecs > DEPTH_V) ? DEPTH_V : num_vecs;
  assign last_vec = (({1'b0, idx_q} + (IDX_W+1)'(1)) == nv_q);

  // An X/Z on y fails the equality test and falls through to a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (y == rd_vec.exp_y) mismatch = 1'b0;
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    nv_n    = nv_q;
    cnt_n   = cnt_q;
    a_n     = a_q;
    b_n     = b_q;
    c_n     = c_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    pass_n  = pass_q;
    err_n   = err_q;
    ff_n    = ff_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nv_n   = nv_clamp;
          idx_n  = '0;
          err_n  = '0;
          ff_n   = '0;
          pass_n = 1'b0;
          if (nv_clamp == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            pass_n  = 1'b1;
          end else begin
            state_n = APPLY;
            busy_n  = 1'b1;
          end
        end
      end
      APPLY: begin
        a_n     = rd_vec.a;
        b_n     = rd_vec.b;
        c_n     = rd_vec.c;
        cnt_n   = SETTLE_V;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) state_n = CHECK;
        else             cnt_n   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q == '0)     ff_n  = idx_q;
          if (err_q != DEPTH_V) err_n = err_q + (IDX_W+1)'(1);
        end
        if (last_vec) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
          a_n     = 1'b0;
          b_n     = 1'b0;
          c_n     = 1'b0;
        end else begin
          idx_n   = idx_q + IDX_W'(1);
          state_n = APPLY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nv_q    <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      nv_q    <= nv_n;
      cnt_q   <= cnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
      c_q     <= c_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      ff_q    <= ff_n;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_behav_seq_ctrl.sv
// Directed bench for behav_seq_ctrl; y comes from a stand-in model y = (a & b) | c.
module tb_behav_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int SET   = 2;
  localparam int IW    = 3;
  localparam int PER   = 2 + SET;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [3:0]    wr_vec;
  logic [IW:0]   num_vecs;
  logic          start;
  logic          a, b, c, y;
  logic          busy, done, pass;
  logic [IW:0]   err_cnt;
  logic [IW-1:0] first_fail;

  logic [3:0]    tbl [DEPTH];
  int            checks = 0;
  int            errors = 0;
  int            bcyc, dk;

  always #5 clk = ~clk;

  assign y = (a & b) | c;

  behav_seq_ctrl #(.DEPTH(DEPTH), .SETTLE_CYC(SET)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_vec     (wr_vec),
    .num_vecs   (num_vecs),
    .start      (start),
    .a          (a),
    .b          (b),
    .c          (c),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input int addr, input logic [3:0] v);
    wr_en   = 1'b1;
    wr_addr = IW'(addr);
    wr_vec  = v;
    tick();
    wr_en   = 1'b0;
    tbl[addr] = v;
  endtask

  // Starts a run and follows it until done (bounded); counts busy cycles and
  // reports the cycle offset of the done pulse (-1 if it never came).
  task automatic run(input logic [IW:0] nv, input int exp_n, input bit chk_abc,
                     input bit inject, output int bc, output int dkk);
    num_vecs = nv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wr_en    = 1'b0;
    bc  = 0;
    dkk = -1;
    for (int k = 0; k < 100; k++) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        dkk = k;
        break;
      end
      if (chk_abc && (k % PER) == 1 && (k / PER) < exp_n)
        check("abc_apply", {a, b, c}, tbl[k/PER][3:1]);
      if (inject && k == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_vec = 4'b0001;
      end else if (inject && k == 3) begin
        start = 1'b0; wr_en = 1'b0;
      end
      tick();
    end
  endtask

  task automatic results(input string tag, input int exp_bc, input int exp_dk,
                         input logic exp_pass, input int exp_err, input int exp_ff);
    check({tag, "_busy_cycles"}, bc_l(), exp_bc);
    check({tag, "_done_at"}, dk, exp_dk);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_first_fail"}, first_fail, exp_ff);
    tick();
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_abc_idle"}, {a, b, c}, 3'b000);
    check({tag, "_pass_held"}, pass, exp_pass);
  endtask

  function automatic int bc_l();
    return bcyc;
  endfunction

  initial begin
    int dcount;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_vec = '0;
    num_vecs = '0; start = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_abc", {a, b, c}, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err", err_cnt, 0);
    check("rst_ff", first_fail, 0);

    // Four vectors that agree with the model.
    wr(0, 4'b1101);
    wr(1, 4'b0100);
    wr(2, 4'b0011);
    wr(3, 4'b1000);
    run(4, 4, 1'b1, 1'b0, bcyc, dk);
    results("good4", 16, 16, 1'b1, 0, 0);

    // Entries 1 and 3 with inverted expectation.
    wr(1, 4'b0101);
    wr(3, 4'b1001);
    run(4, 4, 1'b1, 1'b0, bcyc, dk);
    results("bad13", 16, 16, 1'b0, 2, 1);

    // Empty run.
    run(0, 0, 1'b0, 1'b0, bcyc, dk);
    results("empty", 0, 0, 1'b1, 0, 0);

    // Start and write to entry 0 during a run are both ignored.
    wr(1, 4'b0100);
    wr(3, 4'b1000);
    run(4, 4, 1'b0, 1'b1, bcyc, dk);
    results("inject", 16, 16, 1'b1, 0, 0);
    run(4, 4, 1'b1, 1'b0, bcyc, dk);
    results("rerun", 16, 16, 1'b1, 0, 0);

    // Reset during SETTLE of vector 1.
    num_vecs = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("midrun_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_abc", {a, b, c}, 3'b000);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_err", err_cnt, 0);
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0) dcount++;
      tick();
    end
    check("rstmid_no_done", dcount, 0);
    run(4, 4, 1'b1, 1'b0, bcyc, dk);
    results("after_rst", 16, 16, 1'b1, 0, 0);

    // All eight entries mismatch; num_vecs=9 clamps to 8.
    for (int i = 0; i < DEPTH; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      wr(i, {abc, ~((abc[2] & abc[1]) | abc[0])});
    end
    run(9, 8, 1'b1, 1'b0, bcyc, dk);
    results("clamp", 32, 32, 1'b0, 8, 0);

    // Write and start in the same cycle: the run sees the new entry 0.
    wr_en = 1'b1; wr_addr = '0; wr_vec = 4'b1101;
    tbl[0] = 4'b1101;
    run(1, 1, 1'b1, 1'b0, bcyc, dk);
    results("wr_start", 4, 4, 1'b1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
